// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : 5-stage pipeline write-enable/bubble control for load-use,
//            taken-branch and multi-cycle mul/div hazards, with
//            saturating stall and flush counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned PERF_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IDEX_MemRead_i,
    input  logic [4:0]        IDEX_Rt_i,
    input  logic [4:0]        IFID_Rs_i,
    input  logic [4:0]        IFID_Rt_i,
    input  logic              muldiv_start_i,
    input  logic              branch_taken_i,
    input  logic              perf_clr_i,
    output logic              PC_Write_o,
    output logic              IFID_Write_o,
    output logic              IDEX_Write_o,
    output logic              EXMEM_Write_o,
    output logic              MEMWB_Write_o,
    output logic              IFID_Bubble_o,
    output logic              IDEX_Bubble_o,
    output logic              EXMEM_Bubble_o,
    output logic              md_busy_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]        c_MD_INIT   = 8'(MD_LAT - 1);
    localparam bit                c_MD_SINGLE = (MD_LAT == 1);
    localparam logic [PERF_W-1:0] c_PERF_MAX  = '1;

    state_t            state_q, state_d;
    logic [7:0]        md_cnt_q, md_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_load_use;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_idex_write;
    logic w_ifid_bubble;
    logic w_idex_bubble;
    logic w_exmem_bubble;

    // r0 is hardwired zero, so a load "to" r0 never creates a dependency
    assign w_load_use = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                        ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_idex_write   = 1'b1;
        w_ifid_bubble  = 1'b0;
        w_idex_bubble  = 1'b0;
        w_exmem_bubble = 1'b0;

        if (branch_taken_i) begin
            // Flush everything younger than MEM, including a pending mul/div
            w_ifid_bubble  = 1'b1;
            w_idex_bubble  = 1'b1;
            w_exmem_bubble = 1'b1;
            state_d        = RUN;
            md_cnt_d       = 8'd0;
        end else if (state_q == MD_WAIT) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_write   = 1'b0;
            w_exmem_bubble = 1'b1;
            if (md_cnt_q == 8'd1) begin
                state_d  = RUN;
                md_cnt_d = 8'd0;
            end else begin
                md_cnt_d = md_cnt_q - 8'd1;
            end
        end else if (muldiv_start_i) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_write   = 1'b0;
            w_exmem_bubble = 1'b1;
            if (!c_MD_SINGLE) begin
                state_d  = MD_WAIT;
                md_cnt_d = c_MD_INIT;
            end
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!w_pc_write && (stall_cnt_q != c_PERF_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (branch_taken_i && (flush_cnt_q != c_PERF_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            md_cnt_q    <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC_Write_o     = w_pc_write;
    assign IFID_Write_o   = w_ifid_write;
    assign IDEX_Write_o   = w_idex_write;
    assign EXMEM_Write_o  = 1'b1;
    assign MEMWB_Write_o  = 1'b1;
    assign IFID_Bubble_o  = w_ifid_bubble;
    assign IDEX_Bubble_o  = w_idex_bubble;
    assign EXMEM_Bubble_o = w_exmem_bubble;
    assign md_busy_o      = (state_q == MD_WAIT);
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

`default_nettype wire
